// File: rtl/fpgaboy_pkg.sv
// Shared constants and helper functions for the fpgaboy peripheral blocks.
package fpgaboy_pkg;

    // Number of bits needed to hold values 0 .. value-1.
    function automatic int clog2(input longint value);
        int     result;
        longint span;
        result = 0;
        span   = 1;
        while (span < value) begin
            span   = span * 2;
            result = result + 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/debounce_chan.sv
// One debounce channel: synchroniser chain, candidate register, saturating
// stability counter, clean level and registered rise/fall strobes.
module debounce_chan
    import fpgaboy_pkg::*;
#(
    parameter int   DELAY       = 1000000,
    parameter int   SYNC_STAGES = 2,
    parameter logic RESET_BIT   = 1'b0
) (
    input  logic clock,
    input  logic reset,
    input  logic tick,
    input  logic noisy,
    output logic clean,
    output logic rise,
    output logic fall
);

    localparam int               CNT_W = clog2(DELAY + 1);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(DELAY);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync;
    logic                   cand;
    logic [CNT_W-1:0]       count;

    assign sync = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync_q <= {SYNC_STAGES{RESET_BIT}};
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], noisy};
        end
    end

    // A change on sync always restarts the window, even once the count has
    // saturated, so a late toggle holds clean at its old value.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cand  <= RESET_BIT;
            count <= '0;
            clean <= RESET_BIT;
            rise  <= 1'b0;
            fall  <= 1'b0;
        end else begin
            rise <= 1'b0;
            fall <= 1'b0;
            if (sync != cand) begin
                cand  <= sync;
                count <= '0;
            end else if (count == LIMIT && clean != cand) begin
                clean <= cand;
                rise  <= cand;
                fall  <= ~cand;
            end else if (tick && count < LIMIT) begin
                count <= count + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/debounce_bank.sv
// Bank of WIDTH independent debounce channels with a global change flag
// formed from the per-channel rise/fall strobes.
module debounce_bank
    import fpgaboy_pkg::*;
#(
    parameter int               WIDTH       = 8,
    parameter int               DELAY       = 1000000,
    parameter int               SYNC_STAGES = 2,
    parameter logic [WIDTH-1:0] RESET_VAL   = '0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             tick,
    input  logic [WIDTH-1:0] noisy,
    output logic [WIDTH-1:0] clean,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall,
    output logic             changed
);

    if (DELAY < 1) begin : g_bad_delay
        $error("debounce_bank: DELAY must be at least 1");
    end
    if (SYNC_STAGES < 2) begin : g_bad_sync
        $error("debounce_bank: SYNC_STAGES must be at least 2");
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_chan
        debounce_chan #(
            .DELAY      (DELAY),
            .SYNC_STAGES(SYNC_STAGES),
            .RESET_BIT  (RESET_VAL[i])
        ) u_chan (
            .clock(clock),
            .reset(reset),
            .tick (tick),
            .noisy(noisy[i]),
            .clean(clean[i]),
            .rise (rise[i]),
            .fall (fall[i])
        );
    end

    assign changed = |(rise | fall);

endmodule
